// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM state
// encoding and the default operand width.
package div_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 32'd8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple arithmetic chains.
module FullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/rc_subtractor.sv
// Ripple-borrow subtractor diff = a - b, built from full adders computing
// a + ~b + 1. borrow_o is high when b > a (no carry out of the chain).
module rc_subtractor #(
   parameter int unsigned N = 32'd9
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] diff_o,
   output logic         borrow_o
);

   logic [N:0] carry_s;

   assign carry_s[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_bit
      FullAdder u_fa (
         .a_i   (a_i[i]),
         .b_i   (~b_i[i]),
         .cin_i (carry_s[i]),
         .sum_o (diff_o[i]),
         .cout_o(carry_s[i+1])
      );
   end

   assign borrow_o = ~carry_s[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; results are held in output registers until
// the next completion or reset.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned   CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 32'd1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;
   logic             borrow_s;
   logic             fits_s;
   logic [WIDTH-1:0] r_step_s;
   logic [WIDTH-1:0] q_step_s;

   // Partial remainder shifted left with the next dividend bit entering at the bottom.
   assign shifted_s = {r_q, q_q[WIDTH-1]};

   rc_subtractor #(.N(WIDTH + 32'd1)) u_sub (
      .a_i     (shifted_s),
      .b_i     ({1'b0, dvsr_q}),
      .diff_o  (diff_s),
      .borrow_o(borrow_s)
   );

   // The borrow and the sign bit of the difference agree because the
   // partial remainder is always below the divisor; either says "divisor fits".
   assign fits_s   = ~borrow_s & ~diff_s[WIDTH];
   assign r_step_s = fits_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
   assign q_step_s = {q_q[WIDTH-2:0], fits_s};

   // Next-state logic: operand capture, one restoring step per RUN cycle, result load.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      r_d         = r_q;
      q_d         = q_q;
      dvsr_d      = dvsr_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (divisor == {WIDTH{1'b0}}) begin
                  state_d     = ST_DONE;
                  quotient_d  = {WIDTH{1'b1}};
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  r_d     = {WIDTH{1'b0}};
                  q_d     = dividend;
                  dvsr_d  = divisor;
                  count_d = CNT_ZERO;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            r_d     = r_step_s;
            q_d     = q_step_s;
            count_d = count_q + CNT_ONE;
            if (count_q == LAST_STEP) begin
               state_d     = ST_DONE;
               quotient_d  = q_step_s;
               remainder_d = r_step_s;
               dbz_d       = 1'b0;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, working and result registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= CNT_ZERO;
         r_q         <= {WIDTH{1'b0}};
         q_q         <= {WIDTH{1'b0}};
         dvsr_q      <= {WIDTH{1'b0}};
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         r_q         <= r_d;
         q_q         <= q_d;
         dvsr_q      <= dvsr_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: a cycle-level behavioural
// model of the 8-bit instance checked every cycle, directed vectors with
// literal results, and a 16-bit instance checked per operation.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  dividend = 8'd0;
   logic [7:0]  divisor = 8'd0;
   logic        busy, done, div_by_zero;
   logic [7:0]  quotient, remainder;

   logic        start16 = 1'b0;
   logic [15:0] dividend16 = 16'd0;
   logic [15:0] divisor16 = 16'd0;
   logic        busy16, done16, dbz16;
   logic [15:0] quotient16, remainder16;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   seq_restoring_divider #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   seq_restoring_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .dividend(dividend16), .divisor(divisor16),
      .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
      .div_by_zero(dbz16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Behavioural model: an accepted division finishes W+1 cycles later, a zero divisor next cycle.
   int         m_left = 0;
   logic       m_done = 1'b0;
   logic       m_dz = 1'b0;
   logic [7:0] m_q = 8'd0, m_r = 8'd0, m_pq = 8'd0, m_pr = 8'd0;

   // Model update on every clock edge, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0; m_done <= 1'b0; m_q <= 8'd0; m_r <= 8'd0; m_dz <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_q <= m_pq; m_r <= m_pr; m_dz <= 1'b0; m_done <= 1'b1;
         end else begin
            m_done <= 1'b0;
         end
      end else if (start) begin
         if (divisor == 8'd0) begin
            m_q <= 8'hFF; m_r <= dividend; m_dz <= 1'b1; m_done <= 1'b1;
         end else begin
            m_pq <= dividend / divisor; m_pr <= dividend % divisor;
            m_left <= W; m_done <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   // Per-cycle comparison of the 8-bit DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc busy", {31'd0, busy}, {31'd0, m_left > 0});
         chk("cyc done", {31'd0, done}, {31'd0, m_done});
         chk("cyc quotient", {24'd0, quotient}, {24'd0, m_q});
         chk("cyc remainder", {24'd0, remainder}, {24'd0, m_r});
         chk("cyc div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
      end
   end

   // Called at a falling edge: present a start for one edge; returns in cycle 1.
   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input logic [7:0] eq, input logic [7:0] er,
                            input logic edz, input int elat, input string nm);
      int cyc;
      bit seen_busy;
      cyc = cyc0;
      seen_busy = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) seen_busy = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk({nm, " latency"}, cyc, elat);
      chk({nm, " quotient"}, {24'd0, quotient}, {24'd0, eq});
      chk({nm, " remainder"}, {24'd0, remainder}, {24'd0, er});
      chk({nm, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
      chk({nm, " busy seen"}, {31'd0, seen_busy}, {31'd0, elat > 1});
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic edz, input int elat, input string nm);
      @(negedge clk);
      issue(a, b);
      wait_done(1, eq, er, edz, elat, nm);
   endtask

   task automatic run8_auto(input logic [7:0] a, input logic [7:0] b);
      if (b == 8'd0) run8(a, b, 8'hFF, a, 1'b1, 1, "sweep8");
      else           run8(a, b, a / b, a % b, 1'b0, 9, "sweep8");
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b);
      int cyc;
      @(negedge clk);
      dividend16 = a; divisor16 = b; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      cyc = 1;
      while (done16 !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      if (b == 16'd0) begin
         chk("w16 latency", cyc, 1);
         chk("w16 quotient", {16'd0, quotient16}, 32'h0000FFFF);
         chk("w16 remainder", {16'd0, remainder16}, {16'd0, a});
         chk("w16 div_by_zero", {31'd0, dbz16}, 32'd1);
      end else begin
         chk("w16 latency", cyc, 17);
         chk("w16 quotient", {16'd0, quotient16}, {16'd0, a / b});
         chk("w16 remainder", {16'd0, remainder16}, {16'd0, a % b});
         chk("w16 div_by_zero", {31'd0, dbz16}, 32'd0);
      end
   endtask

   initial begin
      bit seen_done;
      logic [7:0] ra, rb;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst quotient", {24'd0, quotient}, 32'd0);
      chk("rst remainder", {24'd0, remainder}, 32'd0);
      chk("rst div_by_zero", {31'd0, div_by_zero}, 32'd0);
      chk("rst busy16", {31'd0, busy16}, 32'd0);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Directed vectors with hand-computed results
      run8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, "100/7");
      @(negedge clk);
      chk("done single pulse", {31'd0, done}, 32'd0);
      run8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, "255/1");
      run8(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, "5/9");
      run8(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9, "0/3");

      // Start during RUN is ignored; start in the DONE cycle is accepted
      @(negedge clk);
      issue(8'd200, 8'd13);
      repeat (3) @(negedge clk);
      dividend = 8'd9; divisor = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(5, 8'd15, 8'd5, 1'b0, 9, "200/13");
      issue(8'd9, 8'd3);
      wait_done(1, 8'd3, 8'd0, 1'b0, 9, "9/3 b2b");

      // Divide by zero
      run8(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, "37/0");

      // Asynchronous reset in cycle 5 of a run
      @(negedge clk);
      issue(8'd100, 8'd7);
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async busy", {31'd0, busy}, 32'd0);
      chk("async done", {31'd0, done}, 32'd0);
      chk("async quotient", {24'd0, quotient}, 32'd0);
      chk("async remainder", {24'd0, remainder}, 32'd0);
      chk("async div_by_zero", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      chk("no done after abort", {31'd0, seen_done}, 32'd0);
      run8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, "100/7 after reset");

      // 8-bit sweep: boundaries then random
      run8_auto(8'd255, 8'd255);
      run8_auto(8'd1, 8'd255);
      run8_auto(8'd254, 8'd1);
      run8_auto(8'd128, 8'd2);
      run8_auto(8'd255, 8'd0);
      run8_auto(8'd3, 8'd4);
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run8_auto(ra, rb);
      end

      // 16-bit instance: boundaries then random
      run16(16'd65535, 16'd1);
      run16(16'd65535, 16'd65535);
      run16(16'd1000, 16'd1001);
      run16(16'd50000, 16'd0);
      run16(16'd12345, 16'd67);
      for (int i = 0; i < 8; i++) begin
         run16(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 65535)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
